// File: rtl/decode_pkg.sv
// decode_pkg: format encoding, field widths and the decoded-bundle type
// shared by the decode stage and its field extractor.
package decode_pkg;

   localparam int OPC_W   = 11;
   localparam int REG_W   = 5;
   localparam int SHAMT_W = 6;
   localparam int IMM_W   = 64;   // widest legal DATA_W; top slices down

   typedef enum logic [2:0] {
      FMT_R  = 3'd0,
      FMT_I  = 3'd1,
      FMT_D  = 3'd2,
      FMT_B  = 3'd3,
      FMT_CB = 3'd4,
      FMT_IW = 3'd5
   } fmt_t;

   typedef struct packed {
      fmt_t               fmt;
      logic [OPC_W-1:0]   opcode;
      logic [REG_W-1:0]   rm;
      logic [REG_W-1:0]   rn;
      logic [REG_W-1:0]   rd;
      logic [SHAMT_W-1:0] shamt;
      logic [IMM_W-1:0]   imm;
   } decoded_t;

endpackage

// File: rtl/decode_fields.sv
// decode_fields: purely combinational format classification and field /
// immediate extraction for one 32-bit instruction. The immediate is built
// 64 bits wide; sign extension to 64 then truncation equals sign extension
// to any narrower DATA_W.
module decode_fields
   import decode_pkg::*;
(
   input  logic [31:0] instr,
   output decoded_t    dec
);

   // classify by opcode prefix (first match wins) and build the immediate
   always_comb begin
      dec        = '0;
      dec.opcode = instr[31:21];
      dec.rm     = instr[20:16];
      dec.shamt  = instr[15:10];
      dec.rn     = instr[9:5];
      dec.rd     = instr[4:0];
      if (instr[30:26] == 5'b00101) begin
         dec.fmt = FMT_B;
         dec.imm = {{38{instr[25]}}, instr[25:0]};
      end else if ((instr[31:25] == 7'b1011010) || (instr[31:24] == 8'h54)) begin
         dec.fmt = FMT_CB;
         dec.imm = {{45{instr[23]}}, instr[23:5]};
      end else if (instr[28:23] == 6'b100101) begin
         dec.fmt = FMT_IW;
         dec.imm = {48'd0, instr[20:5]};
      end else if ((instr[28:24] == 5'b10001) || (instr[28:24] == 5'b10010)) begin
         dec.fmt = FMT_I;
         dec.imm = {52'd0, instr[21:10]};
      end else if ((instr[29:27] == 3'b111) && (instr[26:24] == 3'b000)) begin
         dec.fmt = FMT_D;
         dec.imm = {{55{instr[20]}}, instr[20:12]};
      end else begin
         dec.fmt = FMT_R;
         dec.imm = {58'd0, instr[15:10]};
      end
   end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: decodes each instruction as it is accepted and holds the
// decoded bundle plus its PC in a 2-entry skid FIFO. Outputs always show
// the head entry. Optional DECODE_PERF_EN adds pop and stall counters.
module decode_stage
   import decode_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int INSTR_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [DATA_W-1:0]  in_pc,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2:0]         out_fmt,
   output logic [10:0]        out_opcode,
   output logic [4:0]         out_rm,
   output logic [4:0]         out_rn,
   output logic [4:0]         out_rd,
   output logic [5:0]         out_shamt,
   output logic [DATA_W-1:0]  out_imm,
`ifdef DECODE_PERF_EN
   output logic [31:0]        perf_decoded,
   output logic [31:0]        perf_stall,
`endif
   output logic [DATA_W-1:0]  out_pc
);

   if (INSTR_W != 32) begin : g_bad_instr_w
      $error("decode_stage: INSTR_W must be 32");
   end
   if ((DATA_W < 32) || (DATA_W > 64)) begin : g_bad_data_w
      $error("decode_stage: DATA_W must be 32..64");
   end

   logic [1:0]        count;
   logic              wr_ptr;
   logic              rd_ptr;
   logic              push;
   logic              pop;
   decoded_t          dec;
   decoded_t          ent [2];
   logic [DATA_W-1:0] pc_q [2];

   // in_ready comes from registered occupancy only
   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   decode_fields u_fields (
      .instr (in_instr),
      .dec   (dec)
   );

   // occupancy and pointers; flush discards everything including same-cycle push/pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else if (flush) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // payload write at the tail slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            ent[i]  <= '0;
            pc_q[i] <= '0;
         end
      end else if (push && !flush) begin
         ent[wr_ptr]  <= dec;
         pc_q[wr_ptr] <= in_pc;
      end
   end

   assign out_fmt    = ent[rd_ptr].fmt;
   assign out_opcode = ent[rd_ptr].opcode;
   assign out_rm     = ent[rd_ptr].rm;
   assign out_rn     = ent[rd_ptr].rn;
   assign out_rd     = ent[rd_ptr].rd;
   assign out_shamt  = ent[rd_ptr].shamt;
   assign out_imm    = ent[rd_ptr].imm[DATA_W-1:0];
   assign out_pc     = pc_q[rd_ptr];

`ifdef DECODE_PERF_EN
   logic pop_eff;
   assign pop_eff = pop & ~flush;

   // event counters survive flush; only rst_n clears them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_decoded <= 32'd0;
         perf_stall   <= 32'd0;
      end else begin
         perf_decoded <= perf_decoded + {31'd0, pop_eff};
         perf_stall   <= perf_stall + {31'd0, (out_valid & ~out_ready)};
      end
   end
`endif

endmodule
